// File: rtl/regfile.sv
// 32 x width register file: two combinational read ports, a debug read port and a committed-write counter.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto rd1/rd2.
module regfile #(
  parameter int               width   = 32,
  parameter logic [width-1:0] sp_init = 'h0000_2ffc
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [4:0]       wa,
  input  logic [width-1:0] wd,
  input  logic [4:0]       ra1,
  input  logic [4:0]       ra2,
  output logic [width-1:0] rd1,
  output logic [width-1:0] rd2,
  input  logic [4:0]       dbg_ra,
  output logic [width-1:0] dbg_rd,
  output logic [15:0]      wr_cnt
);

  localparam int SP_IDX = 29;

  logic [width-1:0] regs [32];
  logic             commit;

  // Register 0 is hardwired, so writes to it are not committed and not counted.
  assign commit = we && (wa != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= (i == SP_IDX) ? sp_init : '0;
      end
      wr_cnt <= '0;
    end else if (commit) begin
      regs[wa] <= wd;
      wr_cnt   <= wr_cnt + 16'd1;
    end
  end

  always_comb begin
    rd1    = (ra1 == 5'd0)    ? '0 : regs[ra1];
    rd2    = (ra2 == 5'd0)    ? '0 : regs[ra2];
    dbg_rd = (dbg_ra == 5'd0) ? '0 : regs[dbg_ra];
`ifdef REGFILE_BYPASS_EN
    // commit already excludes wa==0, so a matching ra is nonzero too.
    if (rst_n && commit && (ra1 == wa)) rd1 = wd;
    if (rst_n && commit && (ra2 == wa)) rd2 = wd;
`endif
  end

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: stimulus queues expected values, a monitor pops and compares on each sample strobe.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;
  logic [4:0]  ra1 = '0;
  logic [4:0]  ra2 = '0;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [4:0]  dbg_ra = '0;
  logic [31:0] dbg_rd;
  logic [15:0] wr_cnt;

  regfile #(.width(32), .sp_init(32'h0000_2ffc)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .dbg_ra(dbg_ra), .dbg_rd(dbg_rd), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  typedef enum int {P_RD1, P_RD2, P_DBG, P_CNT} port_t;
  typedef struct {
    string       name;
    port_t       port;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic chk_strobe = 1'b0;

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] BYP_RD2 = 32'h1234_5678;
`else
  localparam logic [31:0] BYP_RD2 = 32'h0000_0000;
`endif

  task automatic expect_val(input string name, input port_t port, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.port = port;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic sample();
    chk_strobe = 1'b1;
    #1;
    chk_strobe = 1'b0;
  endtask

  // Monitor: drains the scoreboard against live DUT outputs on every strobe.
  initial begin
    forever begin
      @(posedge chk_strobe);
      while (sb.size() > 0) begin
        exp_t        e;
        logic [31:0] act;
        e = sb.pop_front();
        case (e.port)
          P_RD1:   act = rd1;
          P_RD2:   act = rd2;
          P_DBG:   act = dbg_rd;
          default: act = {16'h0000, wr_cnt};
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    // Asynchronous reset with clk held low.
    #2 rst_n = 1'b0;
    ra1 = 5'd7; ra2 = 5'd29; dbg_ra = 5'd29;
    #1;
    expect_val("reset_rd1_r7", P_RD1, 32'h0);
    expect_val("reset_rd2_sp", P_RD2, 32'h0000_2ffc);
    expect_val("reset_dbg_sp", P_DBG, 32'h0000_2ffc);
    expect_val("reset_cnt",    P_CNT, 32'h0);
    sample();

    // Release reset and present a write to r5 in the same cycle.
    @(negedge clk);
    rst_n = 1'b1;
    we = 1'b1; wa = 5'd5; wd = 32'h1234_5678; ra2 = 5'd5; dbg_ra = 5'd5;
    #1;
    expect_val("bypass_rd2_pre", P_RD2, BYP_RD2);
    expect_val("dbg_no_bypass",  P_DBG, 32'h0);
    sample();
    @(posedge clk);
    @(negedge clk);
    expect_val("r5_after_edge", P_RD2, 32'h1234_5678);
    expect_val("cnt_first",     P_CNT, 32'd1);
    sample();

    // Write r8.
    we = 1'b1; wa = 5'd8; wd = 32'hdead_beef;
    @(posedge clk);
    @(negedge clk);
    we = 1'b0; ra1 = 5'd8; dbg_ra = 5'd8;
    #1;
    expect_val("r8_rd1",  P_RD1, 32'hdead_beef);
    expect_val("r8_dbg",  P_DBG, 32'hdead_beef);
    expect_val("cnt_two", P_CNT, 32'd2);
    sample();

    // Write to r0 is discarded and not counted.
    @(negedge clk);
    we = 1'b1; wa = 5'd0; wd = 32'hffff_ffff; ra1 = 5'd0;
    #1;
    expect_val("r0_pre_edge", P_RD1, 32'h0);
    sample();
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
    #1;
    expect_val("r0_rd1",      P_RD1, 32'h0);
    expect_val("cnt_r0_skip", P_CNT, 32'd2);
    sample();

    // we=0 leaves storage alone.
    @(negedge clk);
    we = 1'b0; wa = 5'd9; wd = 32'h5a5a_5a5a; ra1 = 5'd9;
    @(posedge clk);
    @(negedge clk);
    expect_val("we0_r9",  P_RD1, 32'h0);
    expect_val("we0_cnt", P_CNT, 32'd2);
    sample();

    // Same address on both ports.
    ra1 = 5'd8; ra2 = 5'd8;
    #1;
    expect_val("same_rd1", P_RD1, 32'hdead_beef);
    expect_val("same_rd2", P_RD2, 32'hdead_beef);
    sample();

    // Reset collides with a write to r3.
    @(negedge clk);
    we = 1'b1; wa = 5'd3; wd = 32'h0000_00aa;
    ra1 = 5'd8; ra2 = 5'd29; dbg_ra = 5'd3;
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    expect_val("coll_r3",  P_DBG, 32'h0);
    expect_val("coll_cnt", P_CNT, 32'h0);
    expect_val("coll_r8",  P_RD1, 32'h0);
    expect_val("coll_sp",  P_RD2, 32'h0000_2ffc);
    sample();

    // Counter wrap: 65535, 65536 and 65537 committed writes to r1.
    @(negedge clk);
    rst_n = 1'b1;
    we = 1'b1; wa = 5'd1; wd = 32'h5555_5555; ra1 = 5'd1; ra2 = 5'd2;
    for (int i = 0; i < 65535; i++) @(posedge clk);
    @(negedge clk);
    expect_val("cnt_ffff", P_CNT, 32'h0000_ffff);
    sample();
    @(posedge clk);
    @(negedge clk);
    expect_val("cnt_wrap0", P_CNT, 32'h0);
    sample();
    wd = 32'h0bad_f00d;
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
    #1;
    expect_val("cnt_wrap1", P_CNT, 32'd1);
    expect_val("r1_last",   P_RD1, 32'h0bad_f00d);
    sample();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
